user_priority_arbiter: RTL and testbench
========================================

// Module: user_priority_arbiter
// PURPOSE
//  Arbitrates two users that request functions from the shared LED matrix/LED outputs.
//  Per cycle it does three things:
//  - compares both users' 3-bit privilege codes and picks the winner;
//  - checks whether the two requested functions collide;
//  - drives the 7-segment digit with the losing (lower-priority) user's code.
//  Sits between the switch/button input stage and the per-user function decoders / output muxes.
// PARAMETERS
//  none (widths fixed: user code 3 b, function code 3 b, segment bus 8 b)
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  rst       in   1  synchronous reset, active-high
//  user0     in   3  privilege code of user 0 (unsigned, larger = higher priority; 5 = admin, 1 = user)
//  user1     in   3  privilege code of user 1
//  func0     in   3  function requested by user 0 (000 = neutral/no request)
//  func1     in   3  function requested by user 1
//  eq        out  1  func0 == func1
//  prio      out  2  one-hot winner: [0] = user0 wins, [1] = user1 wins
//  en        out  2  per-user output enable: [0] user0 drives outputs, [1] user1 drives outputs
//  user_low  out  3  code of the lower-priority user
//  seg       out  8  active-low segments {DP,G,F,E,D,C,B,A} showing user_low as digit 0-7
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - All outputs are registered.
//  - Latency: 1 cycle from inputs to outputs; a new result every cycle; no handshake.
//  - Reset values: eq=0, prio=2'b00, en=2'b00, user_low=3'b000, seg=8'hFF (blank).
//  - Reset wins over any input on the same edge.
//  - A mid-operation reset blanks the display on the next edge.
//  - Priority:
//    - user0 > user1 -> prio=01, user_low=user1.
//    - user1 > user0 -> prio=10, user_low=user0.
//    - Tie (user0 == user1) -> user0 wins: prio=01, user_low=user1.
//    - prio is always exactly one-hot outside reset.
//  - Conflict = eq AND (func0 != 000).
//    - Neutral requests never conflict.
//  - en = conflict ? prio : 2'b11.
//    - Differing or neutral requests let both users execute.
//  - seg encoding (active-low, DP always 1):
//    - 0=C0, 1=F9, 2=A4, 3=B0
//    - 4=99, 5=92, 6=82, 7=F8
//  - Comparisons are unsigned 3-bit; no wrap or overflow cases exist.
// STRUCTURE
//  - Shared package: USER_W=3, FUNC_W=3, FUNC_NEUTRAL=3'b000, the SEG_* digit constants and SEG_BLANK=8'hFF.
//  - Sub-module seg7_user_decoder: combinational 3-bit -> 8-bit active-low digit pattern, instantiated once.
//  - Comparator and equality logic stay inline, followed by a single output register stage.
// TESTING
//  - Collision: user0=5, func0=1, user1=1, func1=1.
//    Next cycle: eq=1, prio=01, en=01, user_low=1, seg=F9.
//  - No collision: user0=5, func0=2, user1=1, func1=1.
//    Next cycle: eq=0, prio=01, en=11, user_low=1, seg=F9.
//  - user1 wins: user0=1, func0=3, user1=5, func1=3.
//    Next cycle: eq=1, prio=10, en=10, user_low=1, seg=F9.
//  - Tie and neutral:
//    - user0=user1=3, func0=func1=0 -> eq=1, prio=01, en=11, user_low=3, seg=B0.
//    - Same users, func0=func1=4 -> en=01.
//  - Reset: assert rst mid-stream with the collision stimulus applied.
//    Next edge: all outputs at reset values (seg=FF, en=00). First edge after release shows the collision result.
//  - Sweep: loop user_low 0..7 (user0=7, user1=k).
//    seg matches the table for every k; prio=01 throughout (k=7 is the tie case).

Source files
------------

// File: rtl/user_priority_arbiter_pkg.sv
// Shared widths, neutral function code and 7-segment digit patterns for the
// two-user priority arbiter.
package user_priority_arbiter_pkg;

  localparam int USER_W = 3;
  localparam int FUNC_W = 3;
  localparam int SEG_W  = 8;
  localparam int PRIO_W = 2;

  localparam logic [FUNC_W-1:0] FUNC_NEUTRAL = 3'b000;

  // Active-low {DP,G,F,E,D,C,B,A}; DP is never lit.
  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  typedef enum logic [PRIO_W-1:0] {
    PRIO_NONE  = 2'b00,
    PRIO_USER0 = 2'b01,
    PRIO_USER1 = 2'b10
  } prio_t;

  localparam logic [PRIO_W-1:0] EN_NONE = 2'b00;
  localparam logic [PRIO_W-1:0] EN_BOTH = 2'b11;

endpackage

// File: rtl/user_priority_arbiter_if.sv
// Signal bundle between the input stage (master) and the arbiter (slave).
interface user_priority_arbiter_if;
  import user_priority_arbiter_pkg::*;

  // No valid/ready: every rising edge samples user/func and the registered
  // eq/prio/en/user_low/seg reflect that sample from the following edge on.
  logic [USER_W-1:0] user0;
  logic [USER_W-1:0] user1;
  logic [FUNC_W-1:0] func0;
  logic [FUNC_W-1:0] func1;
  logic              eq;
  logic [PRIO_W-1:0] prio;
  logic [PRIO_W-1:0] en;
  logic [USER_W-1:0] user_low;
  logic [SEG_W-1:0]  seg;

  modport master (
    output user0, user1, func0, func1,
    input  eq, prio, en, user_low, seg
  );

  modport slave (
    input  user0, user1, func0, func1,
    output eq, prio, en, user_low, seg
  );

endinterface

// File: rtl/user_priority_arbiter_seg7_user_decoder.sv
// Combinational 3-bit user code to active-low 7-segment digit pattern.
module seg7_user_decoder
  import user_priority_arbiter_pkg::*;
(
  input  logic [USER_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      3'd0: seg = SEG_0;
      3'd1: seg = SEG_1;
      3'd2: seg = SEG_2;
      3'd3: seg = SEG_3;
      3'd4: seg = SEG_4;
      3'd5: seg = SEG_5;
      3'd6: seg = SEG_6;
      3'd7: seg = SEG_7;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/user_priority_arbiter.sv
// Two-user privilege arbiter: picks a winner, detects colliding function
// requests, gates per-user output enables and shows the loser's code.
module user_priority_arbiter
  import user_priority_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  user_priority_arbiter_if.slave bus
);

  logic              user1_wins;
  logic [PRIO_W-1:0] prio_d;
  logic [USER_W-1:0] user_low_d;
  logic              eq_d;
  logic              conflict;
  logic [PRIO_W-1:0] en_d;
  logic [SEG_W-1:0]  seg_d;

  logic              eq_q;
  logic [PRIO_W-1:0] prio_q;
  logic [PRIO_W-1:0] en_q;
  logic [USER_W-1:0] user_low_q;
  logic [SEG_W-1:0]  seg_q;

  // Ties go to user0, so only a strictly larger user1 code wins.
  always_comb begin
    user1_wins = (bus.user1 > bus.user0);
    prio_d     = user1_wins ? PRIO_USER1 : PRIO_USER0;
    user_low_d = user1_wins ? bus.user0 : bus.user1;
    eq_d       = (bus.func0 == bus.func1);
    conflict   = eq_d && (bus.func0 != FUNC_NEUTRAL);
    en_d       = conflict ? prio_d : EN_BOTH;
  end

  seg7_user_decoder u_seg7 (
    .code (user_low_d),
    .seg  (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q       <= 1'b0;
      prio_q     <= PRIO_NONE;
      en_q       <= EN_NONE;
      user_low_q <= '0;
      seg_q      <= SEG_BLANK;
    end else begin
      eq_q       <= eq_d;
      prio_q     <= prio_d;
      en_q       <= en_d;
      user_low_q <= user_low_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.eq       = eq_q;
  assign bus.prio     = prio_q;
  assign bus.en       = en_q;
  assign bus.user_low = user_low_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_user_priority_arbiter.sv
// Scoreboard bench for user_priority_arbiter: directed cases, digit sweep and
// randomized traffic against a behavioural model.
module tb_user_priority_arbiter;

  localparam int W = 16; // {eq, prio[1:0], en[1:0], user_low[2:0], seg[7:0]}

  logic clk;
  logic rst;

  user_priority_arbiter_if bus ();

  user_priority_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] seg_ref [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                              8'h99, 8'h92, 8'h82, 8'hF8};

  function automatic logic [W-1:0] pack(input logic e, input logic [1:0] p,
                                        input logic [1:0] n, input logic [2:0] low,
                                        input logic [7:0] s);
    return {e, p, n, low, s};
  endfunction

  // Reference: winner is the larger code (user0 on ties), loser shown on the digit,
  // both users enabled unless they request the same non-neutral function.
  function automatic logic [W-1:0] model(input logic [2:0] u0, input logic [2:0] u1,
                                         input logic [2:0] f0, input logic [2:0] f1,
                                         input logic r);
    int winner;
    int loser_code;
    logic same;
    logic [1:0] p;
    logic [1:0] n;
    logic [2:0] low;
    if (r) return pack(1'b0, 2'b00, 2'b00, 3'd0, 8'hFF);
    winner     = (int'(u1) > int'(u0)) ? 1 : 0;
    loser_code = (winner == 1) ? int'(u0) : int'(u1);
    low        = loser_code[2:0];
    p          = 2'b00;
    p[winner]  = 1'b1;
    same       = (f0 == f1);
    n          = (same && f0 != 3'd0) ? p : 2'b11;
    return pack(same, p, n, low, seg_ref[loser_code]);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [2:0] u0, input logic [2:0] u1,
                       input logic [2:0] f0, input logic [2:0] f1,
                       input logic r, input logic [W-1:0] exp);
    @(negedge clk);
    rst       = r;
    bus.user0 = u0;
    bus.user1 = u1;
    bus.func0 = f0;
    bus.func1 = f1;
    exp_q.push_back(exp);
  endtask

  task automatic drive_model(input logic [2:0] u0, input logic [2:0] u1,
                             input logic [2:0] f0, input logic [2:0] f1,
                             input logic r);
    drive(u0, u1, f0, f1, r, model(u0, u1, f0, f1, r));
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = {bus.eq, bus.prio, bus.en, bus.user_low, bus.seg};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual{eq,prio,en,low,seg}=%b_%b_%b_%0d_%h expected=%b_%b_%b_%0d_%h",
                 $time, got[15], got[14:13], got[12:11], got[10:8], got[7:0],
                 e[15], e[14:13], e[12:11], e[10:8], e[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] u0, u1, f0, f1;
    logic       r;
    logic [2:0] k3;

    rst = 1'b1;
    bus.user0 = '0;
    bus.user1 = '0;
    bus.func0 = '0;
    bus.func1 = '0;

    // Reset state, including reset winning over live inputs.
    drive(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, pack(1'b0, 2'b00, 2'b00, 3'd0, 8'hFF));
    drive(3'd5, 3'd1, 3'd1, 3'd1, 1'b1, pack(1'b0, 2'b00, 2'b00, 3'd0, 8'hFF));

    // Directed cases.
    drive(3'd5, 3'd1, 3'd1, 3'd1, 1'b0, pack(1'b1, 2'b01, 2'b01, 3'd1, 8'hF9)); // collision
    drive(3'd5, 3'd1, 3'd2, 3'd1, 1'b0, pack(1'b0, 2'b01, 2'b11, 3'd1, 8'hF9)); // no collision
    drive(3'd1, 3'd5, 3'd3, 3'd3, 1'b0, pack(1'b1, 2'b10, 2'b10, 3'd1, 8'hF9)); // user1 wins
    drive(3'd3, 3'd3, 3'd0, 3'd0, 1'b0, pack(1'b1, 2'b01, 2'b11, 3'd3, 8'hB0)); // tie, neutral
    drive(3'd3, 3'd3, 3'd4, 3'd4, 1'b0, pack(1'b1, 2'b01, 2'b01, 3'd3, 8'hB0)); // tie, conflict

    // Mid-stream reset with the collision stimulus held, then release.
    drive(3'd5, 3'd1, 3'd1, 3'd1, 1'b0, pack(1'b1, 2'b01, 2'b01, 3'd1, 8'hF9));
    drive(3'd5, 3'd1, 3'd1, 3'd1, 1'b1, pack(1'b0, 2'b00, 2'b00, 3'd0, 8'hFF));
    drive(3'd5, 3'd1, 3'd1, 3'd1, 1'b0, pack(1'b1, 2'b01, 2'b01, 3'd1, 8'hF9));

    // Digit sweep: user0=7 always wins, user1 walks 0..7 (7 is the tie).
    for (int k = 0; k < 8; k++) begin
      k3 = k[2:0];
      drive(3'd7, k3, 3'd0, 3'd0, 1'b0, pack(1'b1, 2'b01, 2'b11, k3, seg_ref[k]));
    end

    // Randomized traffic; func1 often copies func0 to exercise collisions.
    for (int i = 0; i < 300; i++) begin
      u0 = 3'($urandom_range(0, 7));
      u1 = 3'($urandom_range(0, 7));
      f0 = 3'($urandom_range(0, 7));
      f1 = ($urandom_range(0, 1) == 1) ? f0 : 3'($urandom_range(0, 7));
      r  = ($urandom_range(0, 19) == 0);
      drive_model(u0, u1, f0, f1, r);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
